// File: rtl/gpr_cdb_arbiter_pkg.sv
// GPR CDB arbiter shared types: CDB broadcast bundle, ROB tag width, requester slots.
// Shared by the arbiter, its interface and anything wiring up the GPR CDB.
package gpr_cdb_arbiter_pkg;

    localparam int ROB_WIDTH = 6;

    // Fixed requester slots on the GPR CDB
    localparam int REQ_MOV     = 0;
    localparam int REQ_ALU     = 1;
    localparam int REQ_FPU2GPR = 2;
    localparam int REQ_LOAD    = 3;
    localparam int N_GPR_REQ   = 4;

    typedef struct packed {
        logic                 valid;
        logic [ROB_WIDTH-1:0] tag;
        logic [31:0]          data;
    } cdb_t;

    function automatic logic tag_match(
        input logic [ROB_WIDTH-1:0] tag,
        input cdb_t                 cdb
    );
        return cdb.valid && (cdb.tag == tag);
    endfunction

endpackage

// File: rtl/gpr_cdb_arbiter_if.sv
// GPR CDB request/grant handshake plus broadcast bundle.
// master: requesting units; slave: the arbiter.
interface gpr_cdb_arbiter_if #(
    parameter int N_REQ = 4
);
    import gpr_cdb_arbiter_pkg::*;

    logic [N_REQ-1:0]                req_valid;
    logic [N_REQ-1:0]                req_ready;
    logic [N_REQ-1:0][ROB_WIDTH-1:0] res_tag;
    logic [N_REQ-1:0][31:0]          res_data;
    cdb_t                            gpr_cdb;

    modport master (
        output req_valid, res_tag, res_data,
        input  req_ready, gpr_cdb
    );

    modport slave (
        input  req_valid, res_tag, res_data,
        output req_ready, gpr_cdb
    );

endinterface

// File: rtl/gpr_cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of vec at or after ptr.
// Wraps with an explicit compare so non-power-of-two N never aliases.
module gpr_cdb_arbiter_rr_pick #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        int j;
        j      = 0;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && vec[j]) begin
                any       = 1'b1;
                onehot[j] = 1'b1;
                idx       = W'(j);
            end
        end
    end

endmodule

// File: rtl/gpr_cdb_arbiter.sv
// GPR CDB arbiter: round-robin grant, broadcast one cycle after grant.
// Optional per-unit stall counters under `define GPR_CDB_ARB_PERF_EN.
module gpr_cdb_arbiter
    import gpr_cdb_arbiter_pkg::*;
#(
    parameter  int N_REQ = N_GPR_REQ,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic clk,
    input  logic reset_n,
    gpr_cdb_arbiter_if.slave bus
`ifdef GPR_CDB_ARB_PERF_EN
    ,
    output logic [N_REQ-1:0][31:0] stall_cnt
`endif
);

    logic             reset_done;
    logic [IDX_W-1:0] rr_ptr;
    logic             gnt_vld;
    logic [IDX_W-1:0] gnt_idx;

    logic [N_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             grant;

    gpr_cdb_arbiter_rr_pick #(.N(N_REQ)) u_pick (
        .vec    (bus.req_valid),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // No grants until one clean edge has passed after reset release
    assign grant         = pick_any & reset_done;
    assign bus.req_ready = pick_onehot & {N_REQ{reset_done}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reset_done <= 1'b0;
            rr_ptr     <= '0;
            gnt_vld    <= 1'b0;
            gnt_idx    <= '0;
        end else begin
            reset_done <= 1'b1;
            gnt_vld    <= grant;
            if (grant) begin
                gnt_idx <= pick_idx;
                rr_ptr  <= (pick_idx == IDX_W'(N_REQ - 1)) ?
                           '0 : pick_idx + 1'b1;
            end
        end
    end

    always_comb begin
        bus.gpr_cdb.valid = gnt_vld;
        bus.gpr_cdb.tag   = 'x;
        bus.gpr_cdb.data  = 'x;
        if (gnt_vld) begin
            bus.gpr_cdb.tag  = bus.res_tag[gnt_idx];
            bus.gpr_cdb.data = bus.res_data[gnt_idx];
        end
    end

`ifdef GPR_CDB_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.req_valid[i] && !bus.req_ready[i] &&
                    stall_cnt[i] != 32'hFFFF_FFFF)
                    stall_cnt[i] <= stall_cnt[i] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gpr_cdb_arbiter.sv
// Scoreboard bench for gpr_cdb_arbiter: 4-unit and 3-unit instances.
// Stimulus queues per-cycle expectations; a negedge monitor compares.
module tb_gpr_cdb_arbiter;
    import gpr_cdb_arbiter_pkg::*;

    typedef struct packed {
        logic [3:0]           rdy;
        logic                 cv;
        logic [ROB_WIDTH-1:0] tag;
        logic [31:0]          data;
    } exp_t;

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_err;
    exp_t q4[$];
    exp_t q3[$];
    exp_t e4;
    exp_t e3;

    gpr_cdb_arbiter_if #(.N_REQ(4)) bus4 ();
    gpr_cdb_arbiter_if #(.N_REQ(3)) bus3 ();

`ifdef GPR_CDB_ARB_PERF_EN
    logic [3:0][31:0] stall4;
    logic [2:0][31:0] stall3;
`endif

    gpr_cdb_arbiter #(.N_REQ(4)) dut4 (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus4.slave)
`ifdef GPR_CDB_ARB_PERF_EN
        ,
        .stall_cnt (stall4)
`endif
    );

    gpr_cdb_arbiter #(.N_REQ(3)) dut3 (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus3.slave)
`ifdef GPR_CDB_ARB_PERF_EN
        ,
        .stall_cnt (stall3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] DBASE  = 32'hC0DE_0000;
    localparam logic [31:0] D3BASE = 32'h3000_0000;

    task automatic step(input logic [3:0] v, input logic [3:0] r,
                        input logic cv, input logic [ROB_WIDTH-1:0] t,
                        input logic [31:0] d);
        exp_t e;
        bus4.req_valid = v;
        e = '{rdy: r, cv: cv, tag: t, data: d};
        q4.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic step3(input logic [2:0] v, input logic [2:0] r,
                         input logic cv, input logic [ROB_WIDTH-1:0] t,
                         input logic [31:0] d);
        exp_t e;
        bus3.req_valid = v;
        e = '{rdy: {1'b0, r}, cv: cv, tag: t, data: d};
        q3.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q4.size() > 0) begin
            e4 = q4.pop_front();
            n_vec++;
            if (bus4.req_ready !== e4.rdy) begin
                n_err++;
                $display("FAIL ready4 @%0t: got %b want %b",
                         $time, bus4.req_ready, e4.rdy);
            end
            if (bus4.gpr_cdb.valid !== e4.cv) begin
                n_err++;
                $display("FAIL cdb4.valid @%0t: got %b want %b",
                         $time, bus4.gpr_cdb.valid, e4.cv);
            end else if (e4.cv && (bus4.gpr_cdb.tag !== e4.tag ||
                                   bus4.gpr_cdb.data !== e4.data)) begin
                n_err++;
                $display("FAIL cdb4.payload @%0t: got %0d/%h want %0d/%h",
                         $time, bus4.gpr_cdb.tag, bus4.gpr_cdb.data,
                         e4.tag, e4.data);
            end
        end
        if (q3.size() > 0) begin
            e3 = q3.pop_front();
            n_vec++;
            if (bus3.req_ready !== e3.rdy[2:0]) begin
                n_err++;
                $display("FAIL ready3 @%0t: got %b want %b",
                         $time, bus3.req_ready, e3.rdy[2:0]);
            end
            if (bus3.gpr_cdb.valid !== e3.cv) begin
                n_err++;
                $display("FAIL cdb3.valid @%0t: got %b want %b",
                         $time, bus3.gpr_cdb.valid, e3.cv);
            end else if (e3.cv && (bus3.gpr_cdb.tag !== e3.tag ||
                                   bus3.gpr_cdb.data !== e3.data)) begin
                n_err++;
                $display("FAIL cdb3.payload @%0t: got %0d/%h want %0d/%h",
                         $time, bus3.gpr_cdb.tag, bus3.gpr_cdb.data,
                         e3.tag, e3.data);
            end
        end
    end

    initial begin
        exp_t er;
        n_vec   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        bus4.req_valid = '0;
        bus3.req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            bus4.res_tag[i]  = ROB_WIDTH'(i);
            bus4.res_data[i] = DBASE + 32'(i);
        end
        for (int i = 0; i < 3; i++) begin
            bus3.res_tag[i]  = ROB_WIDTH'(10 + i);
            bus3.res_data[i] = D3BASE + 32'(i);
        end
        @(posedge clk);
        #1;
        // in reset, then the cycle of release
        step(4'b1111, 4'b0000, 1'b0, '0, '0);
        reset_n = 1'b1;
        step(4'b1111, 4'b0000, 1'b0, '0, '0);
        // all four valid: rotate 0,1,2,3,0
        step(4'b1111, 4'b0001, 1'b0, '0, '0);
        step(4'b1111, 4'b0010, 1'b1, 6'd0, DBASE + 32'd0);
        step(4'b1111, 4'b0100, 1'b1, 6'd1, DBASE + 32'd1);
        step(4'b1111, 4'b1000, 1'b1, 6'd2, DBASE + 32'd2);
        step(4'b1111, 4'b0001, 1'b1, 6'd3, DBASE + 32'd3);
        step(4'b0000, 4'b0000, 1'b1, 6'd0, DBASE + 32'd0);
        // lone grant to unit 1, then idle
        step(4'b0010, 4'b0010, 1'b0, '0, '0);
        step(4'b0000, 4'b0000, 1'b1, 6'd1, DBASE + 32'd1);
        step(4'b0000, 4'b0000, 1'b0, '0, '0);
        // pointer held at 2
        bus4.res_tag[2]  = 6'd7;
        bus4.res_data[2] = 32'hDEAD_BEEF;
        step(4'b1111, 4'b0100, 1'b0, '0, '0);
        for (int k = 0; k < 5; k++)
            step(4'b0100, 4'b0100, 1'b1, 6'd7, 32'hDEAD_BEEF);
        step(4'b0000, 4'b0000, 1'b1, 6'd7, 32'hDEAD_BEEF);
        step(4'b0000, 4'b0000, 1'b0, '0, '0);
        bus4.res_tag[2]  = 6'd2;
        bus4.res_data[2] = DBASE + 32'd2;
        // pointer at 3, wraps to 0
        step(4'b1001, 4'b1000, 1'b0, '0, '0);
        step(4'b1001, 4'b0001, 1'b1, 6'd3, DBASE + 32'd3);
        step(4'b0000, 4'b0000, 1'b1, 6'd0, DBASE + 32'd0);
        // grant, then reset pulse with no clock edge in between
        step(4'b0010, 4'b0010, 1'b0, '0, '0);
        bus4.req_valid = 4'b0000;
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        er = '{rdy: 4'b0000, cv: 1'b0, tag: '0, data: '0};
        q4.push_back(er);
        @(posedge clk);
        #1;
        step(4'b1111, 4'b0001, 1'b0, '0, '0);
        step(4'b0000, 4'b0000, 1'b1, 6'd0, DBASE + 32'd0);
        step(4'b0000, 4'b0000, 1'b0, '0, '0);
        // three-unit instance: grant 1, then 2/0 alternate
        step3(3'b010, 3'b010, 1'b0, '0, '0);
        step3(3'b101, 3'b100, 1'b1, 6'd11, D3BASE + 32'd1);
        step3(3'b101, 3'b001, 1'b1, 6'd12, D3BASE + 32'd2);
        step3(3'b101, 3'b100, 1'b1, 6'd10, D3BASE + 32'd0);
        step3(3'b101, 3'b001, 1'b1, 6'd12, D3BASE + 32'd2);
        step3(3'b000, 3'b000, 1'b1, 6'd10, D3BASE + 32'd0);
        step3(3'b000, 3'b000, 1'b0, '0, '0);
`ifdef GPR_CDB_ARB_PERF_EN
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (stall4[i] !== 32'd0) begin
                n_err++;
                $display("FAIL stall_rst[%0d]: got %0d want 0",
                         i, stall4[i]);
            end
        end
        bus4.req_valid = 4'b1111;
        repeat (8) @(posedge clk);
        #1;
        bus4.req_valid = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (stall4[i] !== 32'd6) begin
                n_err++;
                $display("FAIL stall_cnt[%0d]: got %0d want 6",
                         i, stall4[i]);
            end
        end
`endif
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (q4.size() != 0 || q3.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d/%0d pending want 0/0",
                     q4.size(), q3.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
